// File: rtl/alu_flag_cond_unit.sv
// rtl/alu_flag_cond_unit.sv - ALU flag register, branch condition resolver, overflow trap and counter.
// Optional sticky overflow flag built only when ALU_FLAG_STICKY_V_EN is defined.
module alu_flag_cond_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_we,
  input  logic             zin,
  input  logic             vin,
  input  logic             nin,
  input  logic             trap_en,
  input  logic             br_valid,
  input  logic [2:0]       cond,
  output logic             br_done,
  output logic             br_taken,
  output logic [2:0]       flags_q,
  output logic             trap_req,
  input  logic             trap_ack,
  output logic [CNT_W-1:0] ovf_count,
  output logic             sticky_v,
  input  logic             sticky_clr
);

  typedef enum logic {
    IDLE,
    PEND
  } trap_state_t;

  trap_state_t state, state_next;

  logic eff_n, eff_v, eff_z;
  logic cond_result;
  logic ovf_event;

  // A branch in the same cycle as a flag write sees the new flags.
  assign {eff_n, eff_v, eff_z} = flag_we ? {nin, vin, zin} : flags_q;
  assign ovf_event = flag_we & vin;

  always_comb begin
    cond_result = 1'b0;
    case (cond)
      3'b000:  cond_result = eff_z;
      3'b001:  cond_result = ~eff_z;
      3'b010:  cond_result = eff_n ^ eff_v;
      3'b011:  cond_result = ~(eff_n ^ eff_v);
      3'b100:  cond_result = eff_v;
      3'b101:  cond_result = ~eff_v;
      3'b110:  cond_result = 1'b1;
      default: cond_result = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= 3'b000;
      br_done   <= 1'b0;
      br_taken  <= 1'b0;
      ovf_count <= '0;
    end else begin
      if (flag_we) begin
        flags_q <= {nin, vin, zin};
      end
      br_done <= br_valid;
      if (br_valid) begin
        br_taken <= cond_result;
      end
      if (ovf_event && (ovf_count != {CNT_W{1'b1}})) begin
        ovf_count <= ovf_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A fresh trapping overflow outranks the acknowledge of the previous one.
  always_comb begin
    state_next = state;
    trap_req   = 1'b0;
    case (state)
      IDLE: begin
        if (ovf_event && trap_en) begin
          state_next = PEND;
        end
      end
      PEND: begin
        trap_req = 1'b1;
        if (trap_ack && !(ovf_event && trap_en)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ALU_FLAG_STICKY_V_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_v <= 1'b0;
    end else if (ovf_event) begin
      sticky_v <= 1'b1;
    end else if (sticky_clr) begin
      sticky_v <= 1'b0;
    end
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_flag_cond_unit.sv
// tb/tb_alu_flag_cond_unit.sv - directed and randomized check of alu_flag_cond_unit against a behavioural model.
module tb_alu_flag_cond_unit;

  logic       clk = 1'b0;
  logic       reset, flag_we, zin, vin, nin, trap_en, br_valid, trap_ack, sticky_clr;
  logic [2:0] cond;
  logic       br_done, br_taken, trap_req, sticky_v;
  logic [2:0] flags_q;
  logic [7:0] ovf_count;
  logic       br_done2, br_taken2, trap_req2, sticky_v2;
  logic [2:0] flags_q2;
  logic [1:0] ovf_count2;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  bit       m_done, m_taken, m_trap, m_sticky;
  bit [2:0] m_flags;
  int       m_cnt, m_cnt2;

  always #5 clk = ~clk;

  alu_flag_cond_unit #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .flag_we(flag_we), .zin(zin), .vin(vin), .nin(nin),
    .trap_en(trap_en), .br_valid(br_valid), .cond(cond), .br_done(br_done),
    .br_taken(br_taken), .flags_q(flags_q), .trap_req(trap_req), .trap_ack(trap_ack),
    .ovf_count(ovf_count), .sticky_v(sticky_v), .sticky_clr(sticky_clr)
  );

  alu_flag_cond_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .flag_we(flag_we), .zin(zin), .vin(vin), .nin(nin),
    .trap_en(trap_en), .br_valid(br_valid), .cond(cond), .br_done(br_done2),
    .br_taken(br_taken2), .flags_q(flags_q2), .trap_req(trap_req2), .trap_ack(trap_ack),
    .ovf_count(ovf_count2), .sticky_v(sticky_v2), .sticky_clr(sticky_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit eval_cond(input bit [2:0] c, input bit n, input bit v, input bit z);
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return n != v;
      3'd3: return n == v;
      3'd4: return v;
      3'd5: return !v;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    bit [2:0] eff;
    bit ev;
    if (reset) begin
      m_flags = 3'b000; m_done = 0; m_taken = 0; m_trap = 0;
      m_cnt = 0; m_cnt2 = 0; m_sticky = 0;
    end else begin
      eff = flag_we ? {nin, vin, zin} : m_flags;
      ev  = flag_we && vin;
      if (flag_we) m_flags = {nin, vin, zin};
      m_done = br_valid;
      if (br_valid) m_taken = eval_cond(cond, eff[2], eff[1], eff[0]);
      if (ev && m_cnt < 255) m_cnt++;
      if (ev && m_cnt2 < 3) m_cnt2++;
      if (ev && trap_en) m_trap = 1;
      else if (trap_ack) m_trap = 0;
`ifdef ALU_FLAG_STICKY_V_EN
      if (ev) m_sticky = 1;
      else if (sticky_clr) m_sticky = 0;
`endif
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("flags_q", 32'(flags_q), 32'(m_flags));
      check("br_done", 32'(br_done), 32'(m_done));
      check("br_taken", 32'(br_taken), 32'(m_taken));
      check("trap_req", 32'(trap_req), 32'(m_trap));
      check("ovf_count", 32'(ovf_count), 32'(m_cnt));
      check("ovf_count_w2", 32'(ovf_count2), 32'(m_cnt2));
      check("sticky_v", 32'(sticky_v), 32'(m_sticky));
      check("trap_req_w2", 32'(trap_req2), 32'(m_trap));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    reset = 0; flag_we = 0; zin = 0; vin = 0; nin = 0; trap_en = 0;
    br_valid = 0; cond = 3'd0; trap_ack = 0; sticky_clr = 0;
  endtask

  // Apply the currently driven inputs for one edge, then return inputs to idle at the sampling point.
  task automatic step();
    tick();
    idle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    cmp_en = 1'b1;
    idle();
    @(negedge clk); #1;
    check("reset_flags", 32'(flags_q), 32'd0);
    check("reset_cnt", 32'(ovf_count), 32'd0);
    check("reset_trap", 32'(trap_req), 32'd0);

    flag_we = 1; zin = 1; step();
    check("lit_flags_z", 32'(flags_q), 32'b001);
    br_valid = 1; cond = 3'd0; step();
    check("lit_eq_done", 32'(br_done), 32'd1);
    check("lit_eq_taken", 32'(br_taken), 32'd1);
    step();
    check("lit_done_pulse", 32'(br_done), 32'd0);
    check("lit_taken_hold", 32'(br_taken), 32'd1);
    br_valid = 1; cond = 3'd1; step();
    check("lit_ne_taken", 32'(br_taken), 32'd0);

    flag_we = 1; step();
    check("lit_flags_clear", 32'(flags_q), 32'd0);
    flag_we = 1; nin = 1; br_valid = 1; cond = 3'd2; step();
    check("lit_lt_fwd", 32'(br_taken), 32'd1);
    check("lit_flags_n", 32'(flags_q), 32'b100);
    br_valid = 1; cond = 3'd3; step();
    check("lit_ge", 32'(br_taken), 32'd0);

    flag_we = 1; vin = 1; trap_en = 1; step();
    check("lit_trap_set", 32'(trap_req), 32'd1);
    check("lit_cnt1", 32'(ovf_count), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("lit_trap_hold", 32'(trap_req), 32'd1);
    end
    trap_ack = 1; step();
    check("lit_trap_ack", 32'(trap_req), 32'd0);
    check("lit_cnt_after_ack", 32'(ovf_count), 32'd1);
`ifdef ALU_FLAG_STICKY_V_EN
    check("lit_sticky_set", 32'(sticky_v), 32'd1);
    sticky_clr = 1; step();
    check("lit_sticky_clr", 32'(sticky_v), 32'd0);
`else
    check("lit_sticky_off", 32'(sticky_v), 32'd0);
`endif

    flag_we = 1; vin = 1; trap_en = 1; step();
    check("lit_cnt2", 32'(ovf_count), 32'd2);
    check("lit_w2_cnt2", 32'(ovf_count2), 32'd2);
    flag_we = 1; vin = 1; trap_en = 1; trap_ack = 1; sticky_clr = 1; step();
    check("lit_ack_vs_event", 32'(trap_req), 32'd1);
    check("lit_cnt3", 32'(ovf_count), 32'd3);
    check("lit_w2_cnt3", 32'(ovf_count2), 32'd3);
`ifdef ALU_FLAG_STICKY_V_EN
    check("lit_sticky_set_wins", 32'(sticky_v), 32'd1);
`else
    check("lit_sticky_off2", 32'(sticky_v), 32'd0);
`endif
    for (int i = 0; i < 2; i++) begin
      flag_we = 1; vin = 1; step();
      check("lit_w2_sat", 32'(ovf_count2), 32'd3);
    end
    check("lit_cnt5", 32'(ovf_count), 32'd5);
    trap_ack = 1; step();
    check("lit_ack_idle", 32'(trap_req), 32'd0);
    trap_ack = 1; step();
    check("lit_ack_ignored", 32'(trap_req), 32'd0);

    flag_we = 1; vin = 1; trap_en = 1; step();
    check("lit_trap_again", 32'(trap_req), 32'd1);
    reset = 1; step();
    check("lit_reset_trap", 32'(trap_req), 32'd0);
    check("lit_reset_cnt", 32'(ovf_count), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      flag_we    = $urandom_range(0, 1) == 1;
      zin        = $urandom_range(0, 1) == 1;
      vin        = $urandom_range(0, 1) == 1;
      nin        = $urandom_range(0, 1) == 1;
      trap_en    = $urandom_range(0, 3) != 0;
      br_valid   = $urandom_range(0, 1) == 1;
      cond       = 3'($urandom_range(0, 7));
      trap_ack   = $urandom_range(0, 3) == 0;
      sticky_clr = $urandom_range(0, 3) == 0;
      tick();
    end
    idle();
    tick();
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_flag_cond_unit.md
Name: alu_flag_cond_unit

Overview:
- Consumer end of the ALU flag interface (zout/vout/nout).
- Latches the flags from an ALU operation into a flag register and resolves conditional branches against them with one-cycle registered latency.
- Raises an overflow-trap request, held until acknowledged, and keeps a saturating count of overflow events.
- Sits between the ALU and the PC-select and exception logic of the MIPS-lite datapath.

Parameters:
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  input  1  clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- flag_we  input  1  capture zin/vin/nin this cycle
- zin  input  1  ALU zero flag
- vin  input  1  ALU overflow flag
- nin  input  1  ALU negative flag
- trap_en  input  1  enables the overflow trap request
- br_valid  input  1  branch evaluation request
- cond  input  3  condition code for the request
- br_done  output  1  one-cycle pulse: br_taken is valid
- br_taken  output  1  branch decision, held until the next br_done
- flags_q  output  3  registered flags {n,v,z}
- trap_req  output  1  overflow trap pending
- trap_ack  input  1  exception logic accepts the trap
- ovf_count  output  CNT_W  saturating count of captured overflows
- sticky_v  output  1  sticky overflow (see Optional Feature)
- sticky_clr  input  1  clears sticky_v

Behaviour:
- Reset: all outputs are 0 (flags_q=3'b000, br_done=0, br_taken=0, trap_req=0, ovf_count=0, sticky_v=0). The FSM returns to IDLE. Reset mid-trap drops trap_req on the next edge.
- Flag register:
  - flag_we=1: flags_q <= {nin,vin,zin} at the edge.
  - flag_we=0: flags_q holds.
- Effective flags for evaluation:
  - flag_we=1 in the same cycle as br_valid: use the incoming {nin,vin,zin} (forwarding).
  - Otherwise: use flags_q.
- Condition codes, with Z, V, N the effective flags:
  - 000 EQ: Z
  - 001 NE: !Z
  - 010 LT: N^V
  - 011 GE: !(N^V)
  - 100 VS: V
  - 101 VC: !V
  - 110 AL: 1
  - 111 NV: 0
- Branch latency:
  - br_valid sampled at edge k gives br_done=1 and br_taken=result in cycle k+1.
  - br_done is a single-cycle pulse. Back-to-back br_valid gives back-to-back br_done.
  - br_taken holds its last value when br_done=0.
- Overflow event: flag_we=1 and vin=1 in the same cycle.
- ovf_count increments by 1 per overflow event and saturates at 2^CNT_W-1 (no wrap).
- Trap FSM, states IDLE and PEND; trap_req=1 iff state is PEND:
  - IDLE -> PEND: overflow event with trap_en=1.
  - PEND -> IDLE: trap_ack=1, unless a new overflow event with trap_en=1 arrives in the same cycle, in which case the state stays PEND. The new event is counted.
  - trap_ack while IDLE is ignored.
  - trap_en deasserting while PEND does not cancel the request.
- Reset has priority over every other input.

Optional Feature:
- Macro: ALU_FLAG_STICKY_V_EN.
- Defined:
  - sticky_v <= 1 on any overflow event and stays 1 until sticky_clr=1.
  - sticky_clr and an overflow event in the same cycle: set wins, sticky_v=1.
  - Reset clears sticky_v.
- Undefined: sticky_v is tied to 0, sticky_clr is ignored, and no storage is built.

Test Plan:
- Reset, then flag_we with z=1,v=0,n=0, then br_valid with cond=000 -> flags_q=3'b001; br_done pulses one cycle later with br_taken=1. Repeat with cond=001 -> br_taken=0.
- Same-cycle flag_we with n=1,v=0 and br_valid with cond=010, while flags_q=3'b000 -> br_taken=1 (forwarded). Next cycle, cond=011 with no flag_we -> br_taken=0.
- flag_we with v=1 and trap_en=1 -> trap_req=1 the next cycle, held for 5 cycles with no ack. trap_ack=1 -> trap_req=0 the following cycle, and ovf_count=1.
- In PEND, assert trap_ack together with a new overflow event (trap_en=1) -> trap_req stays 1 and ovf_count increments to 2.
- With CNT_W=2, apply 5 overflow events -> ovf_count reads 1,2,3,3,3.
- With ALU_FLAG_STICKY_V_EN defined: one overflow -> sticky_v=1. sticky_clr alone -> 0. sticky_clr together with an overflow -> 1. With the macro undefined, sticky_v stays 0 throughout.
